// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding, CRC-16 constants and helpers
// for the fabric configuration scan loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CLB,
        ST_LOAD_CONN,
        ST_VERIFY,
        ST_DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic CH_CLB  = 1'b0;
    localparam logic CH_CONN = 1'b1;

    // One MSB-first CRC-16/CCITT step for a single serial bit.
    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        din
    );
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fpga_cfg_crc16.sv
// fpga_cfg_crc16: serial CRC-16/CCITT accumulator, one bit per enabled
// cycle; clear has priority over enable and reloads the init value.
module fpga_cfg_crc16
    import fpga_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear, fold in one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams config words LSB-first onto the CLB chain, then
// the connection chain. Define CFG_READBACK_EN to add CRC readback verify.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CLB_CHAIN_LEN  = 1024,
    parameter int CONN_CHAIN_LEN = 4096,
    parameter int WORD_W         = 8
) (
    input  logic              scan_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              clb_scan_in,
    output logic              clb_scan_en,
    input  logic              clb_scan_out,
    output logic              conn_scan_in,
    output logic              conn_scan_en,
    input  logic              conn_scan_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_LEN = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ?
                             CLB_CHAIN_LEN : CONN_CHAIN_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int BL_W    = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CLB_LAST  = CNT_W'(CLB_CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BL_W-1:0]  BL_FULL   = BL_W'(WORD_W);
    localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BL_W-1:0]   bl_q, bl_d;

    logic have;
    logic shift;
    logic last;
    logic accept;
    logic clr_all;
    logic vlast;

    assign have = (bl_q != '0);

`ifdef CFG_READBACK_EN
    logic        vsel_q, vsel_d;
    logic        err_q, err_d;
    logic [15:0] clb_crc_q, clb_crc_d;
    logic [15:0] load_crc;
    logic [15:0] rb_crc;
    logic [15:0] rb_next;
    logic        rb_din;
    logic        load_clr;
    logic        rb_clr;
    logic        rb_en;

    assign vlast    = (state_q == ST_VERIFY) &&
                      (cnt_q == ((vsel_q == CH_CONN) ? CONN_LAST : CLB_LAST));
    assign rb_din   = (vsel_q == CH_CONN) ? conn_scan_out : clb_scan_out;
    assign rb_next  = crc16_step(rb_crc, rb_din);
    assign load_clr = clr_all || ((state_q == ST_LOAD_CLB) && last);
    assign rb_clr   = clr_all || (vlast && (vsel_q == CH_CLB));
    assign rb_en    = (state_q == ST_VERIFY);
    assign err      = err_q;

    fpga_cfg_crc16 u_load_crc (
        .clk (scan_clk),
        .rst (rst),
        .clr (load_clr),
        .en  (shift),
        .din (buf_q[0]),
        .crc (load_crc)
    );

    fpga_cfg_crc16 u_rb_crc (
        .clk (scan_clk),
        .rst (rst),
        .clr (rb_clr),
        .en  (rb_en),
        .din (rb_din),
        .crc (rb_crc)
    );
`else
    logic unused_scan_out;

    assign vlast           = 1'b0;
    assign err             = 1'b0;
    assign unused_scan_out = clb_scan_out ^ conn_scan_out;
`endif

    // Sequencer, word buffer and chain counter next-state plus outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        bl_d         = bl_q;
        cfg_ready    = 1'b0;
        clb_scan_in  = 1'b0;
        clb_scan_en  = 1'b0;
        conn_scan_in = 1'b0;
        conn_scan_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        shift        = 1'b0;
        last         = 1'b0;
        clr_all      = 1'b0;
`ifdef CFG_READBACK_EN
        vsel_d       = vsel_q;
        err_d        = err_q;
        clb_crc_d    = clb_crc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_CLB;
                    cnt_d   = '0;
                    bl_d    = '0;
                    clr_all = 1'b1;
`ifdef CFG_READBACK_EN
                    vsel_d  = CH_CLB;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD_CLB: begin
                busy        = 1'b1;
                shift       = have;
                last        = have && (cnt_q == CLB_LAST);
                clb_scan_en = have;
                clb_scan_in = have && buf_q[0];
                // A word taken on the last CLB bit lands on the conn chain.
                cfg_ready   = (bl_q <= BL_ONE) || last;
                if (last) begin
                    state_d   = ST_LOAD_CONN;
`ifdef CFG_READBACK_EN
                    clb_crc_d = crc16_step(load_crc, buf_q[0]);
`endif
                end
            end
            ST_LOAD_CONN: begin
                busy         = 1'b1;
                shift        = have;
                last         = have && (cnt_q == CONN_LAST);
                conn_scan_en = have;
                conn_scan_in = have && buf_q[0];
                // No word may be taken once the final bit is on the wire.
                cfg_ready    = (bl_q <= BL_ONE) && !last;
                if (last) begin
`ifdef CFG_READBACK_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef CFG_READBACK_EN
            ST_VERIFY: begin
                busy = 1'b1;
                if (vsel_q == CH_CLB) begin
                    clb_scan_en = 1'b1;
                    clb_scan_in = clb_scan_out;
                end else begin
                    conn_scan_en = 1'b1;
                    conn_scan_in = conn_scan_out;
                end
                cnt_d = vlast ? '0 : cnt_q + CNT_ONE;
                if (vlast) begin
                    if (vsel_q == CH_CLB) begin
                        vsel_d = CH_CONN;
                        if (rb_next != clb_crc_q) err_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        if (rb_next != load_crc) err_d = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        accept = cfg_valid && cfg_ready;
        if (shift) begin
            cnt_d = last ? '0 : cnt_q + CNT_ONE;
        end
        if (accept) begin
            buf_d = cfg_data;
            bl_d  = BL_FULL;
        end else if (shift) begin
            buf_d = buf_q >> 1;
            bl_d  = last ? '0 : bl_q - BL_ONE;
        end
    end

    // State, counter and word buffer registers.
    always_ff @(posedge scan_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            bl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            bl_q    <= bl_d;
        end
    end

`ifdef CFG_READBACK_EN
    // Verify chain select, sticky error and saved CLB load CRC.
    always_ff @(posedge scan_clk) begin
        if (rst) begin
            vsel_q    <= CH_CLB;
            err_q     <= 1'b0;
            clb_crc_q <= CRC16_INIT;
        end else begin
            vsel_q    <= vsel_d;
            err_q     <= err_d;
            clb_crc_q <= clb_crc_d;
        end
    end
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed bench, two loader instances (CLB 16 and 12)
// driving shift-register models of both scan chains.
module tb_fpga_cfg_loader;

    logic       clk;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] cfg_data;
    logic       cfg_valid;

    logic a_ready, a_clb_in, a_clb_en, a_conn_in, a_conn_en;
    logic a_busy, a_done, a_err;
    logic b_ready, b_clb_in, b_clb_en, b_conn_in, b_conn_en;
    logic b_busy, b_done, b_err;

    logic [15:0] a_clb  = '0;
    logic [23:0] a_conn = '0;
    logic [11:0] b_clb  = '0;
    logic [23:0] b_conn = '0;
    logic [11:0] b_flip = '0;

    int n_chk = 0;
    int n_err = 0;

    int a_busy_cnt  = 0;
    int a_en_cnt    = 0;
    int a_starve    = 0;
    int a_done_cnt  = 0;
    int b_done_cnt  = 0;

    fpga_cfg_loader #(
        .CLB_CHAIN_LEN  (16),
        .CONN_CHAIN_LEN (24),
        .WORD_W         (8)
    ) u_dut_a (
        .scan_clk      (clk),
        .rst           (rst),
        .start         (start_a),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (a_ready),
        .clb_scan_in   (a_clb_in),
        .clb_scan_en   (a_clb_en),
        .clb_scan_out  (a_clb[0]),
        .conn_scan_in  (a_conn_in),
        .conn_scan_en  (a_conn_en),
        .conn_scan_out (a_conn[0]),
        .busy          (a_busy),
        .done          (a_done),
        .err           (a_err)
    );

    fpga_cfg_loader #(
        .CLB_CHAIN_LEN  (12),
        .CONN_CHAIN_LEN (24),
        .WORD_W         (8)
    ) u_dut_b (
        .scan_clk      (clk),
        .rst           (rst),
        .start         (start_b),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (b_ready),
        .clb_scan_in   (b_clb_in),
        .clb_scan_en   (b_clb_en),
        .clb_scan_out  (b_clb[0]),
        .conn_scan_in  (b_conn_in),
        .conn_scan_en  (b_conn_en),
        .conn_scan_out (b_conn[0]),
        .busy          (b_busy),
        .done          (b_done),
        .err           (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain models: new bit enters at the head (MSB), tail is bit 0.
    always @(posedge clk) begin
        a_clb  <= a_clb_en  ? {a_clb_in,  a_clb[15:1]}  : a_clb;
        a_conn <= a_conn_en ? {a_conn_in, a_conn[23:1]} : a_conn;
        b_clb  <= (b_clb_en ? {b_clb_in,  b_clb[11:1]}  : b_clb) ^ b_flip;
        b_conn <= b_conn_en ? {b_conn_in, b_conn[23:1]} : b_conn;
    end

    // Activity counters sampled away from the active edge.
    always @(negedge clk) begin
        if (a_busy) a_busy_cnt <= a_busy_cnt + 1;
        if (a_clb_en || a_conn_en) a_en_cnt <= a_en_cnt + 1;
        if (a_busy && !a_clb_en && !a_conn_en) a_starve <= a_starve + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        int k;
        k = 0;
        cfg_data  = b;
        cfg_valid = 1'b1;
        while (!(sel ? b_ready : a_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic gap(input bit sel, input bit pulse);
        int k;
        k = 0;
        while (!(sel ? b_ready : a_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("gap_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            start_a = pulse && (i == 2);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input logic exp_err);
        int k;
        k = 0;
        while (!(sel ? b_done : a_done) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(sel ? b_done : a_done), 32'd1);
        check("done_busy", 32'(sel ? b_busy : a_busy), 32'd0);
        check("done_err", 32'(sel ? b_err : a_err), 32'(exp_err));
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    int s_busy, s_en, s_starve, s_done, s_bdone;
    int rb_extra;

    initial begin
`ifdef CFG_READBACK_EN
        rb_extra = 40;
`else
        rb_extra = 0;
`endif
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        cfg_data  = 8'h00;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_out_a", 32'({a_ready, a_clb_in, a_clb_en, a_conn_in,
              a_conn_en, a_busy, a_done, a_err}), 32'd0);
        check("reset_out_b", 32'({b_ready, b_clb_in, b_clb_en, b_conn_in,
              b_conn_en, b_busy, b_done, b_err}), 32'd0);

        // Back-to-back stream onto CLB=16, CONN=24.
        s_busy = a_busy_cnt; s_en = a_en_cnt; s_starve = a_starve;
        s_done = a_done_cnt; s_bdone = b_done_cnt;
        pulse_start(1'b0);
        check("busy_after_start", 32'(a_busy), 32'd1);
        send(1'b0, 8'hA5);
        check("bit0_latency", 32'({a_clb_en, a_clb_in}), 32'd3);
        check("b_idle_ready", 32'(b_ready), 32'd0);
        send(1'b0, 8'h3C);
        send(1'b0, 8'hFF);
        send(1'b0, 8'h00);
        send(1'b0, 8'h81);
        wait_done(1'b0, 1'b0);
        check("t1_clb", 32'(a_clb), 32'h3CA5);
        check("t1_conn", 32'(a_conn), 32'h8100FF);
        check("t1_done_cnt", 32'(a_done_cnt - s_done), 32'd1);
        check("t1_busy_cyc", 32'(a_busy_cnt - s_busy), 32'(41 + rb_extra));
        check("t1_en_cyc", 32'(a_en_cnt - s_en), 32'(40 + rb_extra));
        check("t1_starve", 32'(a_starve - s_starve), 32'd1);
        check("t1_b_done", 32'(b_done_cnt - s_bdone), 32'd0);

        // Reset during bit 7 of the CLB load, with start in the same cycle.
        pulse_start(1'b0);
        send(1'b0, 8'h12);
        repeat (7) @(negedge clk);
        check("rst_pre_en", 32'(a_clb_en), 32'd1);
        rst     = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        check("rst_out_a", 32'({a_ready, a_clb_in, a_clb_en, a_conn_in,
              a_conn_en, a_busy, a_done, a_err}), 32'd0);
        @(negedge clk);
        check("rst_start_ign", 32'(a_busy), 32'd0);
        check("rst_clb_part", 32'(a_clb), 32'h123C);
        check("rst_conn_kept", 32'(a_conn), 32'h8100FF);

        // Fresh reload with starvation gaps and a stray start in LOAD_CONN.
        s_busy = a_busy_cnt; s_starve = a_starve; s_done = a_done_cnt;
        pulse_start(1'b0);
        send(1'b0, 8'hA5);
        gap(1'b0, 1'b0);
        send(1'b0, 8'h3C);
        send(1'b0, 8'hFF);
        gap(1'b0, 1'b1);
        send(1'b0, 8'h00);
        send(1'b0, 8'h81);
        wait_done(1'b0, 1'b0);
        check("t2_clb", 32'(a_clb), 32'h3CA5);
        check("t2_conn", 32'(a_conn), 32'h8100FF);
        check("t2_starve", 32'(a_starve - s_starve), 32'd11);
        check("t2_done_cnt", 32'(a_done_cnt - s_done), 32'd1);
        check("t2_busy_cyc", 32'(a_busy_cnt - s_busy), 32'(51 + rb_extra));

        // Words offered in IDLE are not consumed.
        cfg_data  = 8'h77;
        cfg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("idle_ready", 32'({a_ready, a_busy}), 32'd0);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("idle_clb_hold", 32'(a_clb), 32'h3CA5);

        // Word straddling the CLB end on the CLB=12 instance.
        s_bdone = b_done_cnt;
        pulse_start(1'b1);
        send(1'b1, 8'hFF);
        send(1'b1, 8'h0F);
        send(1'b1, 8'hAA);
`ifdef CFG_READBACK_EN
        b_flip = 12'h001;
        @(negedge clk);
        b_flip = 12'h000;
`endif
        send(1'b1, 8'h55);
        send(1'b1, 8'hC3);
`ifdef CFG_READBACK_EN
        wait_done(1'b1, 1'b1);
        check("t3_clb", 32'(b_clb), 32'hFFE);
        check("t3_err_sticky", 32'(b_err), 32'd1);
`else
        wait_done(1'b1, 1'b0);
        check("t3_clb", 32'(b_clb), 32'hFFF);
`endif
        check("t3_conn", 32'(b_conn), 32'hC355AA);
        check("t3_done_cnt", 32'(b_done_cnt - s_bdone), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
